clks_ctrl: RTL and testbench

//  Sequencer/supervisor for the clock generator that derives clk10/clk20/clk40 from clk.
//  - Drives the generator's rst/enb.
//  - Brings it up after a start request and confirms lock by watching the divided clocks.
//  - Flags ready, stops it on a clk40 low phase, and traps faults (stalled or incoherent dividers).
//  - Sits beside the generator in the clk domain; downstream logic gates on ready.

---
 rtl/clks_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_clks_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clks_ctrl.sv
// clks_ctrl: sequencer and supervisor for the clk10/clk20/clk40 generator.
// Holds the generator in reset until a start request, releases it, confirms
// lock by counting clk40 rising edges, reports ready, drains on a clk40 low
// phase when asked to stop, and traps stalled or incoherent dividers.
//
// Handshake: start and stop are plain levels sampled on every rising clk
// edge. There is no valid/ready pairing. A request takes effect in the cycle
// after it is sampled. The ready output is a status level that downstream
// logic uses as a gate. It does not acknowledge any request.
module clks_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int LOCK_EDGES = 2,
  parameter int WDOG       = 16,
  parameter int CW         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clk10,
  input  logic       clk20,
  input  logic       clk40,
  output logic       gen_rst,
  output logic       gen_enb,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  localparam int LW = (LOCK_EDGES < 2) ? 1 : $clog2(LOCK_EDGES + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WDOG_LIM = CW'(WDOG);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [LW-1:0] LOCK_LIM = LW'(LOCK_EDGES);
  localparam logic [LW-1:0] LOCK_MAX = {LW{1'b1}};
  localparam logic [LW-1:0] LOCK_ONE = LW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_RUN_UP = 3'd2,
    S_READY  = 3'd3,
    S_DRAIN  = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic          gen_rst_q, gen_rst_d;
  logic          gen_enb_q, gen_enb_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          prev10_q, prev20_q, prev40_q;

  logic          t10, t20, t40, rise40, coh_err;
  logic [CW-1:0] wd_next;
  logic          wd_trip;
  logic [LW-1:0] lock_inc;

  // Edge and coherence detection, plus the watchdog's next value.
  // The dividers are registered on clk, so they can be compared directly
  // against last cycle's copy without synchronisers.
  always_comb begin
    t10     = clk10 ^ prev10_q;
    t20     = clk20 ^ prev20_q;
    t40     = clk40 ^ prev40_q;
    rise40  = t40 & clk40;
    // A slower divider may only move on a cycle when every faster one moves.
    coh_err = (t40 & ~(t20 & t10)) | (t20 & ~t10);

    if (t10) begin
      wd_next = '0;
    end else if (gen_enb_q && (cnt_q != CNT_MAX)) begin
      wd_next = cnt_q + CNT_ONE;
    end else begin
      wd_next = cnt_q;
    end
    wd_trip = (wd_next >= WDOG_LIM);

    if (lock_q != LOCK_MAX) begin
      lock_inc = lock_q + LOCK_ONE;
    end else begin
      lock_inc = lock_q;
    end
  end

  // Next-state and next-output decisions. Every output is taken from a flop,
  // so any decision made here becomes visible one cycle later.
  always_comb begin
    state_d   = state_q;
    gen_rst_d = gen_rst_q;
    gen_enb_d = gen_enb_q;
    ready_d   = ready_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    lock_d    = lock_q;

    unique case (state_q)
      S_IDLE: begin
        gen_rst_d = 1'b1;
        gen_enb_d = 1'b0;
        ready_d   = 1'b0;
        cnt_d     = '0;
        lock_d    = '0;
        // start wins over stop; stop is looked at again in RESET.
        if (start) begin
          state_d = S_RESET;
        end
      end

      S_RESET: begin
        gen_rst_d = 1'b1;
        gen_enb_d = 1'b0;
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == RST_LAST) begin
          state_d   = S_RUN_UP;
          gen_rst_d = 1'b0;
          gen_enb_d = 1'b1;
          cnt_d     = '0;
          lock_d    = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RUN_UP: begin
        cnt_d = wd_next;
        if (stop) begin
          state_d   = S_IDLE;
          gen_enb_d = 1'b0;
          gen_rst_d = 1'b1;
          cnt_d     = '0;
          lock_d    = '0;
        end else if (coh_err || wd_trip) begin
          state_d   = S_FAULT;
          fault_d   = 1'b1;
          gen_enb_d = 1'b0;
          gen_rst_d = 1'b1;
          lock_d    = '0;
        end else if (rise40) begin
          if (lock_inc >= LOCK_LIM) begin
            state_d = S_READY;
            ready_d = 1'b1;
            lock_d  = '0;
          end else begin
            lock_d = lock_inc;
          end
        end
      end

      S_READY: begin
        cnt_d   = wd_next;
        ready_d = 1'b1;
        if (coh_err || wd_trip) begin
          state_d   = S_FAULT;
          fault_d   = 1'b1;
          ready_d   = 1'b0;
          gen_enb_d = 1'b0;
          gen_rst_d = 1'b1;
        end else if (stop) begin
          state_d = S_DRAIN;
          ready_d = 1'b0;
        end
      end

      S_DRAIN: begin
        cnt_d   = wd_next;
        ready_d = 1'b0;
        // The generator is switched off only on a falling clk40, so the
        // last clk40 phase that downstream logic sees is low.
        if (coh_err || wd_trip) begin
          state_d   = S_FAULT;
          fault_d   = 1'b1;
          gen_enb_d = 1'b0;
          gen_rst_d = 1'b1;
        end else if (t40 && !clk40) begin
          state_d   = S_IDLE;
          gen_enb_d = 1'b0;
          gen_rst_d = 1'b1;
          cnt_d     = '0;
        end
      end

      S_FAULT: begin
        fault_d   = 1'b1;
        gen_enb_d = 1'b0;
        gen_rst_d = 1'b1;
        ready_d   = 1'b0;
        lock_d    = '0;
        if (start) begin
          state_d = S_RESET;
          fault_d = 1'b0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d   = S_IDLE;
        gen_rst_d = 1'b1;
        gen_enb_d = 1'b0;
        ready_d   = 1'b0;
        cnt_d     = '0;
        lock_d    = '0;
      end
    endcase
  end

  // State, outputs, counters and divider history. An asynchronous reset
  // immediately puts the generator back into reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gen_rst_q <= 1'b1;
      gen_enb_q <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      lock_q    <= '0;
      prev10_q  <= 1'b0;
      prev20_q  <= 1'b0;
      prev40_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gen_rst_q <= gen_rst_d;
      gen_enb_q <= gen_enb_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      prev10_q  <= clk10;
      prev20_q  <= clk20;
      prev40_q  <= clk40;
    end
  end

  assign gen_rst = gen_rst_q;
  assign gen_enb = gen_enb_q;
  assign ready   = ready_q;
  assign fault   = fault_q;
  assign state   = state_q;

endmodule

// File: tb/tb_clks_ctrl.sv
// tb_clks_ctrl: directed bench for clks_ctrl with a behavioural divider model.
module tb_clks_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clk10, clk20, clk40;
  logic       gen_rst, gen_enb, ready, fault;
  logic [2:0] state;

  // Generator model: 40-cycle phase counter, clk10 toggles every 5 cycles.
  int   gc = 0;
  logic g10 = 1'b0, g20 = 1'b0, g40 = 1'b0;
  // Per-signal overrides for fault injection.
  logic o10 = 1'b0, o20 = 1'b0, o40 = 1'b0;
  logic v10 = 1'b0, v20 = 1'b0, v40 = 1'b0;

  assign clk10 = o10 ? v10 : g10;
  assign clk20 = o20 ? v20 : g20;
  assign clk40 = o40 ? v40 : g40;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] OBS_IDLE  = 7'b000_1_0_0_0;
  localparam logic [6:0] OBS_RESET = 7'b001_1_0_0_0;
  localparam logic [6:0] OBS_RUNUP = 7'b010_0_1_0_0;

  typedef struct {
    logic       start;
    logic       stop;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[14];

  clks_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .clk10  (clk10),
    .clk20  (clk20),
    .clk40  (clk40),
    .gen_rst(gen_rst),
    .gen_enb(gen_enb),
    .ready  (ready),
    .fault  (fault),
    .state  (state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Divider model, reset and enabled by the DUT.
  always @(posedge clk) begin : gen_model
    int nc;
    nc = (gc + 1) % 40;
    if (gen_rst) begin
      gc  <= 0;
      g10 <= 1'b0;
      g20 <= 1'b0;
      g40 <= 1'b0;
    end else if (gen_enb) begin
      gc  <= nc;
      g10 <= ((nc / 5) % 2) == 1;
      g20 <= ((nc / 10) % 2) == 1;
      g40 <= ((nc / 20) % 2) == 1;
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (actual=running required=done)");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] obs();
    return {state, gen_rst, gen_enb, ready, fault};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Advance one cycle and land 1ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bring_up(output int t_enb, output int t_rdy, output int saw_fault);
    saw_fault = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    t_enb = 0;
    while (!gen_enb && t_enb < 20) begin
      if (!gen_rst) saw_fault = 1;
      step();
      t_enb++;
    end
    t_rdy = 0;
    while (!ready && t_rdy < 200) begin
      if (fault) saw_fault = 1;
      step();
      t_rdy++;
    end
  endtask

  initial begin : main
    int t_enb, t_rdy, sf, n;

    tbl[0]  = '{1'b1, 1'b0, OBS_RESET};  // start from FAULT clears fault
    tbl[1]  = '{1'b0, 1'b0, OBS_RESET};
    tbl[2]  = '{1'b0, 1'b1, OBS_IDLE};   // abort in RESET cycle 2
    tbl[3]  = '{1'b0, 1'b1, OBS_IDLE};   // stop ignored in IDLE
    tbl[4]  = '{1'b1, 1'b1, OBS_RESET};  // start beats stop
    tbl[5]  = '{1'b0, 1'b1, OBS_IDLE};   // stop re-checked in RESET
    tbl[6]  = '{1'b1, 1'b0, OBS_RESET};
    tbl[7]  = '{1'b0, 1'b0, OBS_RESET};
    tbl[8]  = '{1'b0, 1'b0, OBS_RESET};
    tbl[9]  = '{1'b0, 1'b0, OBS_RESET};
    tbl[10] = '{1'b0, 1'b0, OBS_RUNUP};  // 4th RESET cycle done
    tbl[11] = '{1'b0, 1'b0, OBS_RUNUP};
    tbl[12] = '{1'b0, 1'b1, OBS_IDLE};   // stop in RUN_UP
    tbl[13] = '{1'b0, 1'b0, OBS_IDLE};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_obs", int'(obs()), int'(OBS_IDLE));
    rst = 1'b0;
    step();
    check("idle_after_reset", int'(obs()), int'(OBS_IDLE));

    // Bring-up.
    bring_up(t_enb, t_rdy, sf);
    check("bringup_reset_cycles", t_enb, 4);
    check("bringup_lock_latency", t_rdy, 61);
    check("bringup_no_fault", sf, 0);
    check("bringup_state_ready", int'(state), 3);

    // Graceful stop while clk40 is high.
    check("drain_clk40_high", int'(clk40), 1);
    stop = 1'b1;
    step();
    check("drain_state", int'(state), 4);
    check("drain_ready_low", int'(ready), 0);
    check("drain_enb_held", int'(gen_enb), 1);
    n = 0;
    while (state == 3'd4 && n < 40) begin
      step();
      n++;
    end
    stop = 1'b0;
    check("drain_cycles", n, 19);
    check("drain_end_obs", int'(obs()), int'(OBS_IDLE));

    // Stall: freeze the dividers right after entering READY.
    bring_up(t_enb, t_rdy, sf);
    check("bringup2_lock_latency", t_rdy, 61);
    v10 = clk10; v20 = clk20; v40 = clk40;
    o10 = 1'b1; o20 = 1'b1; o40 = 1'b1;
    n = 0;
    while (state != 3'd5 && n < 40) begin
      step();
      n++;
    end
    check("stall_cycles", n, 16);
    check("stall_obs", int'(obs()), int'(7'b101_1_0_0_1));
    o10 = 1'b0; o20 = 1'b0; o40 = 1'b0;
    step();
    check("fault_sticky", int'(fault), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("fault_restart_obs", int'(obs()), int'(OBS_RESET));

    // Incoherence: clk40 toggles without clk20 during RUN_UP.
    n = 0;
    while (state != 3'd2 && n < 10) begin
      step();
      n++;
    end
    check("runup_entry_cycles", n, 4);
    repeat (2) step();
    v40 = ~g40;
    o40 = 1'b1;
    step();
    check("incoh_state", int'(state), 5);
    check("incoh_fault", int'(fault), 1);
    check("incoh_enb_low", int'(gen_enb), 0);
    o40 = 1'b0;

    // Abort and priority table.
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].start;
      stop  = tbl[i].stop;
      step();
      check($sformatf("table_row%0d", i), int'(obs()), int'(tbl[i].exp));
    end
    start = 1'b0;
    stop  = 1'b0;

    // Stop in RUN_UP after one clk40 rise; lock must restart from zero.
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!gen_enb && n < 20) begin
      step();
      n++;
    end
    repeat (30) step();
    check("abort_still_runup", int'(state), 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("abort_runup_obs", int'(obs()), int'(OBS_IDLE));
    step();
    bring_up(t_enb, t_rdy, sf);
    check("relock_latency", t_rdy, 61);
    check("relock_no_fault", sf, 0);

    // Asynchronous reset in READY, between clock edges.
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_obs", int'(obs()), int'(OBS_IDLE));
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_async_reset_obs", int'(obs()), int'(OBS_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
